// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring radix-2 integer divider answering the
// EX-stage divide handshake. Supports signed (DIV) and unsigned (DIVU)
// operation and returns {remainder, quotient} so HI/LO split directly.
module iter_divider #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Two's-complement negate.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude of an operand: negate only when signed and the MSB is set.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic           sgn);
    return (sgn && v[DATA_W-1]) ? negate(v) : v;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [DATA_W-1:0]     rem_r, rem_s;
  logic [DATA_W-1:0]     dvd_r, dvd_s;
  logic [DATA_W-1:0]     dsr_r, dsr_s;
  logic [DATA_W-1:0]     quo_r, quo_s;
  logic                  neg_quo_r, neg_quo_s;
  logic                  neg_rem_r, neg_rem_s;
  logic [2*DATA_W-1:0]   result_r, result_s;
  logic                  ready_r, ready_s;

  // 33-bit shifted partial remainder and trial difference, so a divisor
  // with its MSB set is still compared and subtracted exactly.
  logic [DATA_W:0]       rem_sh_s;
  logic [DATA_W:0]       diff_s;
  logic                  fits_s;

  assign rem_sh_s = {rem_r, dvd_r[DATA_W-1]};
  assign diff_s   = rem_sh_s - {1'b0, dsr_r};
  assign fits_s   = (rem_sh_s >= {1'b0, dsr_r});

  // Next-state, datapath and output computation for every state.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rem_s     = rem_r;
    dvd_s     = dvd_r;
    dsr_s     = dsr_r;
    quo_s     = quo_r;
    neg_quo_s = neg_quo_r;
    neg_rem_s = neg_rem_r;
    result_s  = result_r;
    ready_s   = ready_r;

    case (state_r)
      IDLE: begin
        ready_s  = 1'b0;
        result_s = {2*DATA_W{1'b0}};
        if (start_i && !annul_i) begin
          dvd_s     = magnitude(opdata1_i, signed_div_i);
          dsr_s     = magnitude(opdata2_i, signed_div_i);
          neg_quo_s = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_s = signed_div_i & opdata1_i[DATA_W-1];
          cnt_s     = CNT_ZERO;
          rem_s     = ZERO_W;
          quo_s     = ZERO_W;
          if (opdata2_i == ZERO_W) begin
            // Divide by zero answers immediately with a zero result.
            state_s = DONE;
            ready_s = 1'b1;
          end else begin
            state_s = BUSY;
            ready_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end

      BUSY: begin
        ready_s = 1'b0;
        if (annul_i) begin
          // Abort wins over finishing the last iteration.
          state_s  = IDLE;
          result_s = {2*DATA_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          // Sign-correction edge after all iterations.
          state_s  = DONE;
          ready_s  = 1'b1;
          result_s = {(neg_rem_r ? negate(rem_r) : rem_r),
                      (neg_quo_r ? negate(quo_r) : quo_r)};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          dvd_s = {dvd_r[DATA_W-2:0], 1'b0};
          if (fits_s) begin
            rem_s = diff_s[DATA_W-1:0];
            quo_s = {quo_r[DATA_W-2:0], 1'b1};
          end else begin
            rem_s = rem_sh_s[DATA_W-1:0];
            quo_s = {quo_r[DATA_W-2:0], 1'b0};
          end
        end
      end

      DONE: begin
        if (!start_i || annul_i) begin
          state_s  = IDLE;
          ready_s  = 1'b0;
          result_s = {2*DATA_W{1'b0}};
        end else begin
          state_s = DONE;
          ready_s = 1'b1;
        end
      end

      default: begin
        state_s  = IDLE;
        ready_s  = 1'b0;
        result_s = {2*DATA_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO_W;
      dvd_r     <= ZERO_W;
      dsr_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= {2*DATA_W{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rem_r     <= rem_s;
      dvd_r     <= dvd_s;
      dsr_r     <= dsr_s;
      quo_r     <= quo_s;
      neg_quo_r <= neg_quo_s;
      neg_rem_r <= neg_rem_s;
      result_r  <= result_s;
      ready_r   <= ready_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and randomized checks of iter_divider against
// an arithmetic reference model.
module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_errors;

  iter_divider #(.DATA_W(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 32'd0) return 64'd0;
    if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return {r, q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold start until ready; edges counts the
  // acceptance edge as edge 1.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] res, output int edges);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges        = 0;
    do begin
      step();
      edges++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && edges < 100);
    check_eq("ready", {63'd0, ready_o}, 64'd1);
    res = result_o;
  endtask

  // Drop start and expect ready/result to clear on the next edge.
  task automatic finish_div(input string tag);
    start_i = 1'b0;
    step();
    check_eq({tag, "_rdy_fall"}, {63'd0, ready_o}, 64'd0);
    check_eq({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  task automatic directed(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_edges);
    logic [63:0] res;
    int edges;
    run_div(sg, a, b, 1'b0, res, edges);
    check_eq({tag, "_res"}, res, exp);
    check_eq({tag, "_lat"}, 64'(edges), 64'(exp_edges));
    finish_div(tag);
  endtask

  initial begin
    logic [63:0] res, held;
    logic [31:0] a, b, q, r;
    logic        sg;
    int          edges;

    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) step();
    check_eq("reset_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("reset_res", result_o, 64'd0);
    rst = 1'b0;
    step();

    // Directed cases with spec-given results.
    directed("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34);
    directed("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 34);
    directed("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 34);
    directed("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  64'h7FFFFFFF_00000001, 34);
    directed("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 34);
    directed("div0_u",      1'b0, 32'd1234,       32'd0,          64'd0, 1);
    directed("div0_s",      1'b1, 32'hFFFF_0000,  32'd0,          64'd0, 1);

    // Annul at iteration 10, then a fresh divide.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    step();
    repeat (10) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    check_eq("annul_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("annul_res", result_o, 64'd0);
    annul_i = 1'b0;
    directed("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

    // Reset at iteration 20, then a fresh divide.
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_F000; opdata2_i = 32'd7; start_i = 1'b1;
    step();
    repeat (20) step();
    rst = 1'b1; start_i = 1'b0;
    step();
    check_eq("rst_mid_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("rst_mid_res", result_o, 64'd0);
    rst = 1'b0;
    directed("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

    // Operands scrambled during BUSY; DONE held for 5 edges.
    run_div(1'b0, 32'd50, 32'd5, 1'b1, res, edges);
    check_eq("stable_res", res, 64'h00000000_0000000A);
    check_eq("stable_lat", 64'(edges), 64'd34);
    held = res;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_rdy", {63'd0, ready_o}, 64'd1);
      check_eq("hold_res", result_o, held);
    end
    finish_div("stable");

    // Annul in DONE behaves like dropping start.
    run_div(1'b0, 32'd21, 32'd4, 1'b0, res, edges);
    check_eq("annul_done_pre", res, 64'h00000001_00000005);
    annul_i = 1'b1;
    step();
    check_eq("annul_done_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("annul_done_res", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    step();

    // Randomized operands against the reference model.
    for (int n = 0; n < 1000; n++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 255));
        1:       b = -32'($urandom_range(1, 255));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd1;
      run_div(sg, a, b, 1'b0, res, edges);
      check_eq("rand_res", res, ref_div(sg, a, b));
      r = res[63:32];
      q = res[31:0];
      check_eq("rand_ident", {32'd0, q * b + r}, {32'd0, a});
      if (sg)
        check_eq("rand_rsign", {63'd0, (r == 32'd0) || (r[31] == a[31])}, 64'd1);
      else
        check_eq("rand_rlt", {63'd0, r < b}, 64'd1);
      finish_div("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
